// File: rtl/timer_cmp_irq.sv
// timer_cmp_irq: wishbone compare/interrupt stage for the free-running timer.
// Four word registers: CMP, PERIOD, CTRL{IRQ_EN,PERIODIC,EN}, STATUS{OVERRUN,PENDING}.
// An equality match against time_i sets PENDING and either re-arms (periodic)
// or disarms (one-shot). irq_o is a registered PENDING & IRQ_EN.
module timer_cmp_irq #(
   parameter logic [31:0] BASE_ADDR = 32'h3002_0010
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [3:0]  wbs_sel_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic [31:0] time_i,
   output logic        irq_o
);

   localparam logic [1:0] REG_CMP    = 2'd0;
   localparam logic [1:0] REG_PERIOD = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   typedef struct packed {
      logic        we;
      logic [1:0]  idx;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wb_req_t;

   wb_req_t     req;
   logic        hit, acc, wr, match;
   logic        ack_q, irq_q;
   logic [31:0] rdata_q, rd_mux;
   logic [31:0] cmp_q, period_q;
   logic        en_q, periodic_q, irq_en_q;
   logic        pending_q, overrun_q;

   // Byte-lane merge of write data into an existing register value.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] wr_v,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++)
         if (sel[i]) res[8*i +: 8] = wr_v[8*i +: 8];
      return res;
   endfunction

   assign req = '{we: wbs_we_i, idx: wbs_adr_i[3:2], dat: wbs_dat_i, sel: wbs_sel_i};

   // A hit is only accepted when ack is low, so a held strobe is served every other cycle.
   assign hit   = wbs_cyc_i & wbs_stb_i &
                  ((wbs_adr_i & ~32'hF) == (BASE_ADDR & ~32'hF));
   assign acc   = hit & ~ack_q;
   assign wr    = acc & req.we;
   assign match = en_q & (time_i == cmp_q);

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = rdata_q;
   assign irq_o     = irq_q;

   // Read mux; STATUS and CTRL reserved bits read as zero.
   always_comb begin
      rd_mux = 32'h0;
      case (req.idx)
         REG_CMP:    rd_mux = cmp_q;
         REG_PERIOD: rd_mux = period_q;
         REG_CTRL:   rd_mux = {29'h0, irq_en_q, periodic_q, en_q};
         REG_STATUS: rd_mux = {30'h0, overrun_q, pending_q};
         default:    rd_mux = 32'h0;
      endcase
   end

   // Bus handshake: one-cycle ack, read data captured alongside it and held until the next read.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ack_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         ack_q <= acc;
         if (acc && !req.we) rdata_q <= rd_mux;
      end
   end

   // CMP/PERIOD: periodic advance on match, a software write on the same edge overrides it.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cmp_q    <= 32'hFFFF_FFFF;
         period_q <= 32'h0;
      end else begin
         if (wr && req.idx == REG_CMP)
            cmp_q <= byte_merge(cmp_q, req.dat, req.sel);
         else if (match && periodic_q)
            cmp_q <= cmp_q + period_q;
         if (wr && req.idx == REG_PERIOD)
            period_q <= byte_merge(period_q, req.dat, req.sel);
      end
   end

   // CTRL: one-shot match disarms EN unless software writes CTRL on the same edge.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         en_q       <= 1'b0;
         periodic_q <= 1'b0;
         irq_en_q   <= 1'b0;
      end else if (wr && req.idx == REG_CTRL && req.sel[0]) begin
         en_q       <= req.dat[0];
         periodic_q <= req.dat[1];
         irq_en_q   <= req.dat[2];
      end else if (match && !periodic_q) begin
         en_q <= 1'b0;
      end
   end

   // STATUS: w1c from software, but a match on the same edge wins (set dominates clear).
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (match) pending_q <= 1'b1;
         else if (wr && req.idx == REG_STATUS && req.sel[0] && req.dat[0]) pending_q <= 1'b0;
         if (match && pending_q) overrun_q <= 1'b1;
         else if (wr && req.idx == REG_STATUS && req.sel[0] && req.dat[1]) overrun_q <= 1'b0;
      end
   end

   // Interrupt output is registered, so it trails PENDING/IRQ_EN changes by one cycle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) irq_q <= 1'b0;
      else         irq_q <= pending_q & irq_en_q;
   end

endmodule

// File: tb/tb_timer_cmp_irq.sv
// Bench for timer_cmp_irq: directed scenarios then randomized bus/timer traffic,
// all outputs compared every cycle against a register-level reference model.
module tb_timer_cmp_irq;

   localparam logic [31:0] BASE = 32'h3002_0010;
   localparam logic [31:0] A_CMP = BASE + 32'h0, A_PER = BASE + 32'h4,
                           A_CTRL = BASE + 32'h8, A_STAT = BASE + 32'hC;

   logic        clk = 1'b0, rstn;
   logic        cyc, stb, we;
   logic [31:0] adr, dat, time_i;
   logic [3:0]  sel;
   logic        ack, irq;
   logic [31:0] rdat;

   int errors = 0, checks = 0;

   // reference model state
   logic [31:0] m_cmp, m_period, m_dat;
   logic        m_en, m_per, m_ien, m_pend, m_ovr, m_ack, m_irq;

   timer_cmp_irq #(.BASE_ADDR(BASE)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr),
      .wbs_dat_i(dat), .wbs_sel_i(sel), .wbs_ack_o(ack), .wbs_dat_o(rdat),
      .time_i(time_i), .irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_cmp = 32'hFFFF_FFFF; m_period = 0; m_dat = 0;
      m_en = 0; m_per = 0; m_ien = 0; m_pend = 0; m_ovr = 0; m_ack = 0; m_irq = 0;
   endtask

   // One clock: predict from the inputs held across the edge, then compare outputs.
   task automatic tick();
      logic        acc, match, n_en, n_per, n_ien, n_pend, n_ovr;
      logic [1:0]  r;
      logic [31:0] n_cmp, n_period, n_dat;
      acc   = cyc && stb && ((adr & ~32'hF) == BASE) && !m_ack;
      r     = adr[3:2];
      match = m_en && (time_i == m_cmp);
      n_cmp = (match && m_per) ? m_cmp + m_period : m_cmp;
      n_en  = (match && !m_per) ? 1'b0 : m_en;
      n_per = m_per; n_ien = m_ien; n_period = m_period;
      n_pend = m_pend; n_ovr = m_ovr; n_dat = m_dat;
      if (acc && we) begin
         case (r)
            2'd0: n_cmp = merge(m_cmp, dat, sel);
            2'd1: n_period = merge(m_period, dat, sel);
            2'd2: if (sel[0]) {n_ien, n_per, n_en} = dat[2:0];
            default: if (sel[0]) begin
               if (dat[0]) n_pend = 0;
               if (dat[1]) n_ovr = 0;
            end
         endcase
      end
      if (match) begin
         if (m_pend) n_ovr = 1;
         n_pend = 1;
      end
      if (acc && !we) begin
         case (r)
            2'd0: n_dat = m_cmp;
            2'd1: n_dat = m_period;
            2'd2: n_dat = {29'h0, m_ien, m_per, m_en};
            default: n_dat = {30'h0, m_ovr, m_pend};
         endcase
      end
      m_irq = m_pend && m_ien;
      @(posedge clk); #1;
      m_cmp = n_cmp; m_period = n_period; m_en = n_en; m_per = n_per; m_ien = n_ien;
      m_pend = n_pend; m_ovr = n_ovr; m_dat = n_dat; m_ack = acc;
      chk("ack_model", 32'(ack), 32'(m_ack));
      chk("dat_model", rdat, m_dat);
      chk("irq_model", 32'(irq), 32'(m_irq));
   endtask

   task automatic bus_idle();
      cyc = 0; stb = 0; we = 0; adr = 0; dat = 0; sel = 0;
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cyc = 1; stb = 1; we = 1; adr = a; dat = d; sel = s;
      tick();
      chk("wr_ack", 32'(ack), 32'h1);
      bus_idle();
      tick();
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hF;
      tick();
      chk("rd_ack", 32'(ack), 32'h1);
      d = rdat;
      bus_idle();
      tick();
   endtask

   initial begin
      logic [31:0] v;
      logic [1:0]  ri;
      rstn = 0; time_i = 0;
      bus_idle();
      model_reset();
      #3;
      chk("rst_ack", 32'(ack), 0); chk("rst_dat", rdat, 0); chk("rst_irq", 32'(irq), 0);
      repeat (2) @(posedge clk);
      #1 rstn = 1;

      // reset values
      wb_read(A_CMP, v);  chk("rst_cmp", v, 32'hFFFF_FFFF);
      wb_read(A_CTRL, v); chk("rst_ctrl", v, 0);
      wb_read(A_STAT, v); chk("rst_status", v, 0);

      // one-shot
      wb_write(A_CMP, 100, 4'hF);
      wb_write(A_CTRL, 5, 4'hF);
      for (int t = 98; t <= 102; t++) begin
         time_i = t;
         tick();
         if (t == 100) chk("os_irq_lag", 32'(irq), 0);
         if (t == 101) chk("os_irq_set", 32'(irq), 1);
      end
      time_i = 0;
      wb_read(A_STAT, v); chk("os_status", v, 1);
      wb_read(A_CTRL, v); chk("os_ctrl", v, 4);
      cyc = 1; stb = 1; we = 1; adr = A_STAT; dat = 1; sel = 4'hF;
      tick();
      chk("os_w1c_irq_c1", 32'(irq), 1);
      bus_idle();
      tick();
      chk("os_w1c_irq_c2", 32'(irq), 0);

      // periodic with wrap
      wb_write(A_CMP, 32'hFFFF_FFF0, 4'hF);
      wb_write(A_PER, 20, 4'hF);
      wb_write(A_CTRL, 7, 4'hF);
      time_i = 32'hFFFF_FFF0; tick(); time_i = 0;
      wb_read(A_CMP, v); chk("per_wrap_cmp", v, 32'h0000_0004);
      time_i = 4; tick(); time_i = 0;
      wb_read(A_STAT, v); chk("per_overrun", v, 3);

      // irq gating
      wb_write(A_CTRL, 3, 4'hF); chk("gate_off", 32'(irq), 0);
      wb_write(A_CTRL, 7, 4'hF); chk("gate_on", 32'(irq), 1);
      wb_read(A_STAT, v);        chk("gate_status", v, 3);

      // collisions
      wb_write(A_STAT, 3, 4'hF);
      time_i = 24;
      wb_write(A_STAT, 1, 4'hF);
      time_i = 0;
      wb_read(A_STAT, v); chk("col_w1c_set_wins", v, 1);
      time_i = 44;
      wb_write(A_CMP, 500, 4'hF);
      time_i = 0;
      wb_read(A_CMP, v);  chk("col_cmp_sw_wins", v, 500);
      wb_read(A_STAT, v); chk("col_status", v, 3);

      // reset mid-transaction
      cyc = 1; stb = 1; we = 1; adr = A_PER; dat = 32'h1234; sel = 4'hF;
      tick();
      rstn = 0;
      #2;
      chk("arst_ack", 32'(ack), 0); chk("arst_dat", rdat, 0); chk("arst_irq", 32'(irq), 0);
      bus_idle();
      model_reset();
      #2 rstn = 1;
      wb_read(A_CMP, v);  chk("arst_cmp", v, 32'hFFFF_FFFF);
      wb_read(A_PER, v);  chk("arst_per", v, 0);
      wb_read(A_CTRL, v); chk("arst_ctrl", v, 0);
      wb_read(A_STAT, v); chk("arst_status", v, 0);

      // byte lanes, held strobe, address miss
      wb_write(A_CMP, 32'hAABB_CCDD, 4'b0010);
      wb_read(A_CMP, v); chk("sel_merge", v, 32'hFFFF_CCFF);
      cyc = 1; stb = 1; we = 0; adr = A_CMP; sel = 4'hF;
      chk("hold_ack0", 32'(ack), 0);
      tick(); chk("hold_ack1", 32'(ack), 1);
      tick(); chk("hold_ack2", 32'(ack), 0);
      tick(); chk("hold_ack3", 32'(ack), 1);
      bus_idle(); tick();
      cyc = 1; stb = 1; we = 1; adr = 32'h3002_0020; dat = 0; sel = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("miss_noack", 32'(ack), 0);
      end
      bus_idle(); tick();
      wb_read(A_CMP, v); chk("miss_nochange", v, 32'hFFFF_CCFF);

      // randomized traffic against the model
      wb_write(A_CMP, 32'($urandom_range(0, 1000)), 4'hF);
      wb_write(A_PER, 32'($urandom_range(0, 50)), 4'hF);
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0) time_i = m_cmp;
         else if ($urandom_range(0, 7) == 0) time_i = $urandom;
         else time_i = m_cmp + $urandom_range(0, 6) - 3;
         cyc = ($urandom_range(0, 2) != 0);
         stb = ($urandom_range(0, 3) != 0);
         we  = 1'($urandom_range(0, 1));
         ri  = 2'($urandom_range(0, 3));
         adr = ($urandom_range(0, 15) == 0) ? 32'h3002_0020 : (BASE | {28'h0, ri, 2'b00});
         dat = (ri == 2'd0 || ri == 2'd1) ? 32'($urandom_range(0, 1200)) : $urandom;
         sel = 4'($urandom_range(0, 15));
         tick();
      end
      bus_idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
